keccak_round_ctrl: RTL

Round sequencer for the slice-parallel Keccak-f[1600] permutation. It drives the `round` index into the round-constant unit `rc` and issues the per-sub-round enable, index and flags to the permutation datapath. It aligns that enable with rc's one-cycle registered constant output and provides the start/busy/done handshake to the SHAKE/cSHAKE absorb/squeeze controller. It sits directly upstream of `rc`.

---
 rtl/keccak_round_ctrl_pkg.sv | 36 +++
 rtl/keccak_round_ctrl_if.sv | 26 ++
 rtl/keccak_round_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/keccak_round_ctrl_pkg.sv
// Shared parameters, state encoding and width helpers for the Keccak round sequencer.
package keccak_round_ctrl_pkg;

    localparam int KRC_NUM_SUB_ROUNDS  = 1;
    localparam int KRC_MAX_ROUND_COUNT = 24 * KRC_NUM_SUB_ROUNDS;
    localparam int KRC_PARALLEL_SLICES = 64 / KRC_NUM_SUB_ROUNDS;

    function automatic int krc_clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (rem > 0) begin
                result = result + 1;
                rem    = rem >> 1;
            end
        end
        return result;
    endfunction

    // The slice selector keeps one bit even when there is only a single slice group.
    function automatic int krc_sel_width(input int nsr);
        return (nsr > 1) ? krc_clog2(nsr) : 1;
    endfunction

    localparam int KRC_ROUND_COUNT_WIDTH = krc_clog2(KRC_MAX_ROUND_COUNT + 1);

    typedef enum logic [1:0] {
        KRC_IDLE  = 2'd0,
        KRC_RUN   = 2'd1,
        KRC_DRAIN = 2'd2,
        KRC_DONE  = 2'd3
    } krc_state_t;

endpackage

// File: rtl/keccak_round_ctrl_if.sv
// Handshake and datapath-control bundle between the round sequencer and its neighbours.
interface keccak_round_ctrl_if #(
    parameter int RCW = 5,
    parameter int SSW = 1
);
    logic           start;
    logic           stall;
    logic [RCW-1:0] round;
    logic           perm_en;
    logic [RCW-1:0] sub_idx;
    logic [SSW-1:0] slice_sel;
    logic           first_sub;
    logic           last_sub;
    logic           busy;
    logic           done;

    modport master (
        input  start, stall,
        output round, perm_en, sub_idx, slice_sel, first_sub, last_sub, busy, done
    );

    modport slave (
        output start, stall,
        input  round, perm_en, sub_idx, slice_sel, first_sub, last_sub, busy, done
    );
endinterface

// File: rtl/keccak_round_ctrl.sv
// Sub-round sequencer for Keccak-f[1600]: drives rc.round and issues perm_en one cycle
// later so that it lines up with the registered round constant.
module keccak_round_ctrl
    import keccak_round_ctrl_pkg::*;
#(
    parameter int NSR  = KRC_NUM_SUB_ROUNDS,
    parameter int MAXR = 24 * NSR,
    parameter int RCW  = krc_clog2(MAXR + 1),
    parameter int SSW  = krc_sel_width(NSR)
) (
    input  logic                 clk,
    input  logic                 rst,
    keccak_round_ctrl_if.master  bus
);

    localparam logic [RCW-1:0] ROUND_IDLE = RCW'(MAXR);
    localparam logic [RCW-1:0] ROUND_LAST = RCW'(MAXR - 1);

    krc_state_t     state_reg;
    krc_state_t     state_next;
    logic [RCW-1:0] round_reg;
    logic [RCW-1:0] round_next;
    logic           perm_en_reg;
    logic [RCW-1:0] sub_idx_reg;
    logic           first_sub_reg;
    logic           last_sub_reg;
    logic           issue;

    assign issue = (state_reg == KRC_RUN) && !bus.stall;

    always_comb begin
        state_next = state_reg;
        round_next = round_reg;
        case (state_reg)
            KRC_IDLE: begin
                if (bus.start) begin
                    state_next = KRC_RUN;
                    round_next = '0;
                end
            end
            KRC_RUN: begin
                // A stalled cycle keeps round, so rc re-fetches the same constant.
                if (!bus.stall) begin
                    round_next = round_reg + RCW'(1);
                    if (round_reg == ROUND_LAST) begin
                        state_next = KRC_DRAIN;
                    end
                end
            end
            KRC_DRAIN: begin
                state_next = KRC_DONE;
            end
            KRC_DONE: begin
                state_next = KRC_IDLE;
            end
            default: begin
                state_next = KRC_IDLE;
                round_next = ROUND_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= KRC_IDLE;
            round_reg     <= ROUND_IDLE;
            perm_en_reg   <= 1'b0;
            sub_idx_reg   <= '0;
            first_sub_reg <= 1'b0;
            last_sub_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            round_reg     <= round_next;
            perm_en_reg   <= issue;
            first_sub_reg <= issue && (round_reg == '0);
            last_sub_reg  <= issue && (round_reg == ROUND_LAST);
            if (issue) begin
                sub_idx_reg <= round_reg;
            end
        end
    end

    assign bus.round     = round_reg;
    assign bus.perm_en   = perm_en_reg;
    assign bus.sub_idx   = sub_idx_reg;
    assign bus.first_sub = first_sub_reg;
    assign bus.last_sub  = last_sub_reg;
    assign bus.busy      = (state_reg != KRC_IDLE);
    assign bus.done      = (state_reg == KRC_DONE);

    generate
        if (NSR > 1) begin : g_slice_sel
            assign bus.slice_sel = sub_idx_reg[SSW-1:0];
        end else begin : g_single_slice
            assign bus.slice_sel = '0;
        end
    endgenerate

endmodule
